// File: rtl/hdl_1_dataflow.sv
// hdl_1_dataflow
//   Combinational 4-input function E = F(A,B,C,D) plus a registered observation
//   path that samples E and its input index when en is high.
//
//   Ports (declaration order is fixed: E, A, B, C, D come first for positional use)
//     E          out 1  F(A,B,C,D) = B'C' + AB' + AD' + AC, zero latency
//     A,B,C,D    in  1  function variables, A is index MSB, D is index LSB
//     clk        in  1  rising-edge clock
//     rst        in  1  synchronous active-high reset, overrides en
//     en         in  1  sample enable for the registered path
//     e_q        out 1  registered E
//     idx_q      out 4  registered index {A,B,C,D}
//     ones_cnt   out 5  enabled samples with E=1, saturates at 31
//     sweep_done out 1  set once every index 0..15 has been sampled since reset
//     mismatch   out 1  sticky disagreement between E and a reference table
//
//   Configuration macro: HDL_1_SELFCHECK_EN
//     Defined   - E is compared against a constant truth table on each enabled
//                 edge; any disagreement sets mismatch until reset.
//     Undefined - no table is built and mismatch is tied low.

module hdl_1_dataflow (
  output logic       E,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       e_q,
  output logic [3:0] idx_q,
  output logic [4:0] ones_cnt,
  output logic       sweep_done,
  output logic       mismatch
);

  localparam logic [4:0]  CntMax  = 5'd31;
  localparam logic [15:0] MaskAll = 16'hFFFF;

  logic [3:0]  idx;
  logic [15:0] idx_onehot;

  logic        e_d;
  logic [3:0]  idx_d;
  logic [4:0]  ones_cnt_q, ones_cnt_d;
  logic [15:0] mask_q, mask_d;
  logic        sweep_done_q, sweep_done_d;

  // Function output: pure dataflow, untouched by reset.
  assign E   = (~B & ~C) | (A & ~B) | (A & ~D) | (A & C);
  assign idx = {A, B, C, D};

  always_comb begin
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  end

  // Next-state for the registered path; everything holds while en is low.
  always_comb begin
    e_d          = e_q;
    idx_d        = idx_q;
    ones_cnt_d   = ones_cnt_q;
    mask_d       = mask_q;
    sweep_done_d = sweep_done_q;
    if (en) begin
      e_d    = E;
      idx_d  = idx;
      mask_d = mask_q | idx_onehot;
      if (E && (ones_cnt_q != CntMax)) begin
        ones_cnt_d = ones_cnt_q + 5'd1;
      end
      // Set on the same edge the mask fills, then held until reset.
      sweep_done_d = sweep_done_q | (mask_d == MaskAll);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q          <= 1'b0;
      idx_q        <= 4'd0;
      ones_cnt_q   <= 5'd0;
      mask_q       <= 16'd0;
      sweep_done_q <= 1'b0;
    end else begin
      e_q          <= e_d;
      idx_q        <= idx_d;
      ones_cnt_q   <= ones_cnt_d;
      mask_q       <= mask_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign ones_cnt   = ones_cnt_q;
  assign sweep_done = sweep_done_q;

`ifdef HDL_1_SELFCHECK_EN
  // Reference truth table, bit n is F for index n.
  localparam logic [15:0] RefTable = 16'hDF03;

  logic mismatch_q, mismatch_d;

  always_comb begin
    mismatch_d = mismatch_q;
    if (en && (RefTable[idx] != E)) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_hdl_1_dataflow.sv
module tb_hdl_1_dataflow;

  logic       E, A, B, C, D;
  logic       clk, rst, en;
  logic       e_q;
  logic [3:0] idx_q;
  logic [4:0] ones_cnt;
  logic       sweep_done;
  logic       mismatch;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected F per index, bit n = F(n): minterms 0,1,8,9,10,11,12,14,15.
  logic [15:0] exp_e;
  int          exp_cnt;

  hdl_1_dataflow dut (
    .E          (E),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .e_q        (e_q),
    .idx_q      (idx_q),
    .ones_cnt   (ones_cnt),
    .sweep_done (sweep_done),
    .mismatch   (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] idx, input logic en_v, input logic rst_v);
    {A, B, C, D} = idx;
    en  = en_v;
    rst = rst_v;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, ".e_q"}, {15'd0, e_q}, 16'd0);
    check({tag, ".idx_q"}, {12'd0, idx_q}, 16'd0);
    check({tag, ".ones_cnt"}, {11'd0, ones_cnt}, 16'd0);
    check({tag, ".sweep_done"}, {15'd0, sweep_done}, 16'd0);
    check({tag, ".mismatch"}, {15'd0, mismatch}, 16'd0);
  endtask

  initial begin
    exp_e = 16'b1101_1111_0000_0011;

    // Reset state.
    drive(4'd0, 1'b0, 1'b1);
    tick();
    check_regs_zero("reset");

    // Combinational sweep with en=0: E follows, registers hold.
    for (int i = 0; i < 16; i++) begin
      drive(i[3:0], 1'b0, 1'b0);
      #4;
      check($sformatf("comb_E[%0d]", i), {15'd0, E}, {15'd0, exp_e[i]});
      tick();
    end
    check_regs_zero("hold_en0");

    // Full enabled sweep after a one-edge reset.
    drive(4'd0, 1'b0, 1'b1);
    tick();
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      drive(i[3:0], 1'b1, 1'b0);
      #4;
      check($sformatf("sweep_E[%0d]", i), {15'd0, E}, {15'd0, exp_e[i]});
      tick();
      if (exp_e[i]) exp_cnt++;
      check($sformatf("sweep_e_q[%0d]", i), {15'd0, e_q}, {15'd0, exp_e[i]});
      check($sformatf("sweep_idx_q[%0d]", i), {12'd0, idx_q}, 16'(i));
      check($sformatf("sweep_cnt[%0d]", i), {11'd0, ones_cnt}, 16'(exp_cnt));
      check($sformatf("sweep_done[%0d]", i), {15'd0, sweep_done}, (i == 15) ? 16'd1 : 16'd0);
    end
    check("sweep_cnt_final", {11'd0, ones_cnt}, 16'd9);
    check("sweep_mismatch", {15'd0, mismatch}, 16'd0);

    // en=0 after a sweep: everything holds although inputs change.
    drive(4'd2, 1'b0, 1'b0);
    tick();
    check("hold_e_q", {15'd0, e_q}, 16'd1);
    check("hold_idx_q", {12'd0, idx_q}, 16'd15);
    check("hold_cnt", {11'd0, ones_cnt}, 16'd9);
    check("hold_done", {15'd0, sweep_done}, 16'd1);

    // rst and en on the same edge: reset wins, E stays combinational.
    drive(4'd0, 1'b1, 1'b1);
    tick();
    check_regs_zero("rst_en");
    check("rst_en.E", {15'd0, E}, 16'd1);

    // Hold index 15 for 40 enabled edges: count saturates at 31.
    for (int k = 1; k <= 40; k++) begin
      drive(4'd15, 1'b1, 1'b0);
      tick();
      check($sformatf("sat_cnt[%0d]", k), {11'd0, ones_cnt}, (k > 31) ? 16'd31 : 16'(k));
    end
    check("sat_done", {15'd0, sweep_done}, 16'd0);
    check("sat_idx_q", {12'd0, idx_q}, 16'd15);

    // Reset mid-sweep discards progress.
    drive(4'd0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(i[3:0], 1'b1, 1'b0);
      tick();
    end
    check("half_cnt_lo", {11'd0, ones_cnt}, 16'd2);
    drive(4'd0, 1'b0, 1'b1);
    tick();
    check("mid_rst_cnt", {11'd0, ones_cnt}, 16'd0);
    for (int i = 8; i < 16; i++) begin
      drive(i[3:0], 1'b1, 1'b0);
      tick();
    end
    // Indices 8..15 hold seven ones (only 13 is zero).
    check("half_cnt_hi", {11'd0, ones_cnt}, 16'd7);
    check("half_done", {15'd0, sweep_done}, 16'd0);

    // Repeats add to the count but not to the mask.
    for (int i = 8; i < 16; i++) begin
      drive(i[3:0], 1'b1, 1'b0);
      tick();
    end
    check("repeat_cnt", {11'd0, ones_cnt}, 16'd14);
    check("repeat_done", {15'd0, sweep_done}, 16'd0);
    for (int i = 0; i < 7; i++) begin
      drive(i[3:0], 1'b1, 1'b0);
      tick();
    end
    check("almost_done", {15'd0, sweep_done}, 16'd0);
    drive(4'd7, 1'b1, 1'b0);
    tick();
    check("late_done", {15'd0, sweep_done}, 16'd1);
    check("late_cnt", {11'd0, ones_cnt}, 16'd16);
    check("late_mismatch", {15'd0, mismatch}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
